// File: rtl/demux_buffered.sv
// Buffered 1-to-2 demultiplexer: routes each accepted word into queue A (sel=1)
// or queue B (sel=0). Each queue is a small FIFO drained by valid/ready.
module demux_buffered #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data,
  output logic [CW-1:0]    a_count,
  output logic [CW-1:0]    b_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] a_mem [DEPTH];
  logic [WIDTH-1:0] b_mem [DEPTH];
  logic [PW-1:0]    a_wr_ptr, a_rd_ptr;
  logic [PW-1:0]    b_wr_ptr, b_rd_ptr;
  logic             a_full, b_full;
  logic             a_push, a_pop, b_push, b_pop;

  assign a_full   = (a_count == FULL);
  assign b_full   = (b_count == FULL);

  // Readiness looks only at registered occupancy, so a full queue refuses a
  // push even if its consumer drains it in the same cycle.
  assign in_ready = in_sel ? !a_full : !b_full;

  assign a_valid  = (a_count != '0);
  assign b_valid  = (b_count != '0);
  assign a_data   = a_valid ? a_mem[a_rd_ptr] : '0;
  assign b_data   = b_valid ? b_mem[b_rd_ptr] : '0;

  assign a_push   = in_valid && in_ready && in_sel;
  assign b_push   = in_valid && in_ready && !in_sel;
  assign a_pop    = a_valid && a_ready;
  assign b_pop    = b_valid && b_ready;

  // Storage is not reset; the zero counts mask its contents after reset.
  always_ff @(posedge clk) begin
    if (a_push) a_mem[a_wr_ptr] <= in_data;
    if (b_push) b_mem[b_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_wr_ptr <= '0;
      a_rd_ptr <= '0;
      a_count  <= '0;
    end else begin
      if (a_push) a_wr_ptr <= a_wr_ptr + 1'b1;
      if (a_pop)  a_rd_ptr <= a_rd_ptr + 1'b1;
      case ({a_push, a_pop})
        2'b10:   a_count <= a_count + 1'b1;
        2'b01:   a_count <= a_count - 1'b1;
        default: a_count <= a_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_wr_ptr <= '0;
      b_rd_ptr <= '0;
      b_count  <= '0;
    end else begin
      if (b_push) b_wr_ptr <= b_wr_ptr + 1'b1;
      if (b_pop)  b_rd_ptr <= b_rd_ptr + 1'b1;
      case ({b_push, b_pop})
        2'b10:   b_count <= b_count + 1'b1;
        2'b01:   b_count <= b_count - 1'b1;
        default: b_count <= b_count;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_buffered.sv
// Directed self-checking bench for demux_buffered (WIDTH=32, DEPTH=2).
module tb_demux_buffered;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sel;
  logic        a_valid;
  logic        a_ready;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [31:0] b_data;
  logic [1:0]  a_count;
  logic [1:0]  b_count;

  int tests_run = 0;
  int tests_failed = 0;

  demux_buffered #(.WIDTH(32), .DEPTH(2), .CW(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic sel,
                               input logic [31:0] data);
    in_valid = valid;
    in_sel   = sel;
    in_data  = data;
    #1;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Occupancy bound monitored throughout the run.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("a_count_bound", {31'd0, a_count <= 2'd2}, 32'd1);
      checkOutput("b_count_bound", {31'd0, b_count <= 2'd2}, 32'd1);
    end
  end

  initial begin
    rst_n = 1'b0;
    a_ready = 1'b0;
    b_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0);
    step();
    step();
    rst_n = 1'b1;

    // Reset while both queues hold words
    applyStimulus(1'b1, 1'b1, 32'h0000_00AA);
    step();
    applyStimulus(1'b1, 1'b0, 32'h0000_00BB);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("pre_reset_a_count", {30'd0, a_count}, 32'd1);
    checkOutput("pre_reset_b_count", {30'd0, b_count}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("rst_a_valid", {31'd0, a_valid}, 32'd0);
    checkOutput("rst_b_valid", {31'd0, b_valid}, 32'd0);
    checkOutput("rst_a_count", {30'd0, a_count}, 32'd0);
    checkOutput("rst_b_count", {30'd0, b_count}, 32'd0);
    checkOutput("rst_a_data", a_data, 32'd0);
    checkOutput("rst_b_data", b_data, 32'd0);
    step();
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'h0);
    checkOutput("rst_in_ready_sel1", {31'd0, in_ready}, 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("rst_in_ready_sel0", {31'd0, in_ready}, 32'd1);

    // Routing with both consumers ready
    a_ready = 1'b1;
    b_ready = 1'b1;
    applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF);
    checkOutput("route_a_valid_before", {31'd0, a_valid}, 32'd0);
    step();
    checkOutput("route_a_valid", {31'd0, a_valid}, 32'd1);
    checkOutput("route_a_data", a_data, 32'hDEAD_BEEF);
    checkOutput("route_b_valid_idle", {31'd0, b_valid}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h1234_5678);
    step();
    checkOutput("route_a_popped", {30'd0, a_count}, 32'd0);
    checkOutput("route_b_valid", {31'd0, b_valid}, 32'd1);
    checkOutput("route_b_data", b_data, 32'h1234_5678);
    applyStimulus(1'b0, 1'b0, 32'h0);
    step();
    checkOutput("route_b_popped", {30'd0, b_count}, 32'd0);

    // Fill A while B remains open
    a_ready = 1'b0;
    b_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'h1);
    step();
    applyStimulus(1'b1, 1'b1, 32'h2);
    step();
    applyStimulus(1'b1, 1'b1, 32'h9);
    checkOutput("full_a_count", {30'd0, a_count}, 32'd2);
    checkOutput("full_a_head", a_data, 32'h1);
    checkOutput("full_in_ready_sel1", {31'd0, in_ready}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h3);
    checkOutput("full_in_ready_sel0", {31'd0, in_ready}, 32'd1);
    step();
    checkOutput("full_b_count", {30'd0, b_count}, 32'd1);
    checkOutput("full_b_data", b_data, 32'h3);
    checkOutput("full_a_count_kept", {30'd0, a_count}, 32'd2);

    // Full A refuses a push even while popping
    a_ready = 1'b1;
    applyStimulus(1'b1, 1'b1, 32'h9);
    checkOutput("refuse_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    checkOutput("refuse_a_count", {30'd0, a_count}, 32'd1);
    checkOutput("refuse_a_head", a_data, 32'h2);
    applyStimulus(1'b0, 1'b0, 32'h0);
    b_ready = 1'b1;
    step();
    checkOutput("drain_a_count", {30'd0, a_count}, 32'd0);
    checkOutput("drain_b_count", {30'd0, b_count}, 32'd0);

    // Back-to-back stream through A with pointer wrap
    b_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h10 + 32'(i));
      checkOutput("stream_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      checkOutput("stream_a_data", a_data, 32'h10 + 32'(i));
      checkOutput("stream_a_count", {30'd0, a_count}, 32'd1);
    end
    applyStimulus(1'b0, 1'b0, 32'h0);
    step();
    checkOutput("stream_drained", {30'd0, a_count}, 32'd0);
    checkOutput("stream_a_data_empty", a_data, 32'd0);

    // Asynchronous reset while A is full
    a_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'h21);
    step();
    applyStimulus(1'b1, 1'b1, 32'h22);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("mid_a_count", {30'd0, a_count}, 32'd2);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_a_valid", {31'd0, a_valid}, 32'd0);
    checkOutput("async_a_count", {30'd0, a_count}, 32'd0);
    step();
    rst_n = 1'b1;
    a_ready = 1'b1;
    step();
    checkOutput("post_rst_a_valid", {31'd0, a_valid}, 32'd0);
    checkOutput("post_rst_a_data", a_data, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
